// File: rtl/sha3_miner_csr.sv
// Avalon-MM register file for the SHA3-256 miner. Optional SHA3_CSR_HASHCNT_EN
// adds a 64-bit run-cycle counter at word 0x16/0x17.
module sha3_miner_csr #(
  parameter int          ADDR_W   = 5,
  parameter logic [17:0] CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic              irq_host,
  output logic [255:0]      header,
  output logic [255:0]      difficulty,
  output logic [63:0]       start_nonce,
  output logic [17:0]       control,
  input  logic [63:0]       solution,
  input  logic [2:0]        status,
  input  logic              irq
);

  logic [31:0] hdr_q [8];
  logic [31:0] dif_q [8];
  logic [31:0] sol_sh;
  logic [31:0] rdata_c;
  logic [31:0] wm;
  logic [7:0]  addr;
  logic        irq_en;
  logic        pending;
  logic        irq_d;
  logic        wr;
  logic        lock;
  logic        irq_rise;
  logic        pend_clr;

  assign avs_waitrequest = 1'b0;
  assign addr     = 8'(avs_address);
  assign wr       = avs_write & ~avs_read;
  assign lock     = control[0];
  assign irq_rise = irq & ~irq_d;

  for (genvar i = 0; i < 8; i++) begin : g_out
    assign header[32*i +: 32]     = hdr_q[i];
    assign difficulty[32*i +: 32] = dif_q[i];
  end

`ifdef SHA3_CSR_HASHCNT_EN
  logic [63:0] cnt;
  logic [31:0] cnt_sh;
  logic        run_d;

  // the cycle that raises run already counts
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      cnt_sh <= '0;
      run_d  <= 1'b0;
    end else begin
      run_d <= status[1];
      cnt   <= ((status[1] & ~run_d) ? 64'd0 : cnt)
             + {63'd0, status[1] & ~status[0]};
      if (avs_read && addr == 8'h16)
        cnt_sh <= cnt[63:32];
    end
  end
`endif

  always_comb begin
    rdata_c = '0;
    unique case (1'b1)
      (addr < 8'h08):  rdata_c = hdr_q[addr[2:0]];
      (addr >= 8'h08 && addr < 8'h10):
                       rdata_c = dif_q[addr[2:0]];
      (addr == 8'h10): rdata_c = start_nonce[31:0];
      (addr == 8'h11): rdata_c = start_nonce[63:32];
      (addr == 8'h12): rdata_c = {14'd0, control};
      (addr == 8'h13): rdata_c = {27'd0, status, pending, irq_en};
      (addr == 8'h14): rdata_c = solution[31:0];
      (addr == 8'h15): rdata_c = sol_sh;
`ifdef SHA3_CSR_HASHCNT_EN
      (addr == 8'h16): rdata_c = cnt[31:0];
      (addr == 8'h17): rdata_c = cnt_sh;
`endif
      default:         rdata_c = '0;
    endcase
  end

  // byte-lane merge of the write data over the current word
  always_comb begin
    wm = rdata_c;
    for (int b = 0; b < 4; b++)
      if (avs_byteenable[b])
        wm[8*b +: 8] = avs_writedata[8*b +: 8];
  end

  always_comb begin
    pend_clr = 1'b0;
    if (wr && addr == 8'h13)
      pend_clr = avs_byteenable[0] & avs_writedata[1];
    if (wr && addr == 8'h12)
      pend_clr = ~wm[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        hdr_q[i] <= '0;
        dif_q[i] <= '0;
      end
      start_nonce       <= '0;
      control           <= CTRL_RST;
      sol_sh            <= '0;
      irq_en            <= 1'b0;
      pending           <= 1'b0;
      irq_d             <= 1'b0;
      irq_host          <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      irq_d             <= irq;
      pending           <= irq_rise | (pending & ~pend_clr);
      irq_host          <= pending & irq_en;
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= rdata_c;
        if (addr == 8'h14)
          sol_sh <= solution[63:32];
      end
      if (wr) begin
        unique case (1'b1)
          (addr < 8'h10): begin
            if (!lock) begin
              if (addr[3]) dif_q[addr[2:0]] <= wm;
              else         hdr_q[addr[2:0]] <= wm;
            end
          end
          (addr == 8'h10): if (!lock) start_nonce[31:0]  <= wm;
          (addr == 8'h11): if (!lock) start_nonce[63:32] <= wm;
          (addr == 8'h12): control <= wm[17:0];
          (addr == 8'h13):
            if (avs_byteenable[0]) irq_en <= avs_writedata[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha3_miner_csr.sv
// Bench for sha3_miner_csr: register-map model checked every cycle,
// plus directed vectors with literal expectations.
module tb_sha3_miner_csr;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   avs_address;
  logic         avs_read;
  logic         avs_write;
  logic [31:0]  avs_writedata;
  logic [3:0]   avs_byteenable;
  logic [31:0]  avs_readdata;
  logic         avs_readdatavalid;
  logic         avs_waitrequest;
  logic         irq_host;
  logic [255:0] header;
  logic [255:0] difficulty;
  logic [63:0]  start_nonce;
  logic [17:0]  control;
  logic [63:0]  solution;
  logic [2:0]   status;
  logic         irq;

  int vectors = 0;
  int miscompares = 0;

  sha3_miner_csr dut (
    .clk(clk), .rst(rst),
    .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest), .irq_host(irq_host),
    .header(header), .difficulty(difficulty),
    .start_nonce(start_nonce), .control(control),
    .solution(solution), .status(status), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: the register map as a flat array of words
  logic [31:0] mem [32];
  logic        men, mpend, mhost, mrdv, irq_prev, started;
  logic [31:0] mrd, msh;
  logic [63:0] mcnt;
  logic [31:0] mcsh;
  logic        mrun_prev;

  function automatic logic [31:0] view(input int a);
    if (a <= 18) return mem[a];
    if (a == 19) return {27'd0, status, mpend, men};
    if (a == 20) return solution[31:0];
    if (a == 21) return msh;
`ifdef SHA3_CSR_HASHCNT_EN
    if (a == 22) return mcnt[31:0];
    if (a == 23) return mcsh;
`endif
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    logic rise, clr;
    logic [31:0] nv;
    int a;
    started = 1'b1;
    a = int'(avs_address);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      {men, mpend, mhost, mrdv, irq_prev} = '0;
      mrd = '0; msh = '0; mcnt = '0; mcsh = '0; mrun_prev = 1'b0;
    end else begin
      mhost = mpend & men;
      rise = irq & ~irq_prev;
      irq_prev = irq;
      clr = 1'b0;
      mrdv = avs_read;
      if (avs_read) begin
        mrd = view(a);
        if (a == 20) msh = solution[63:32];
        if (a == 22) mcsh = mcnt[63:32];
      end else if (avs_write) begin
        nv = view(a);
        for (int b = 0; b < 4; b++)
          if (avs_byteenable[b]) nv[8*b +: 8] = avs_writedata[8*b +: 8];
        if (a <= 17 && !mem[18][0]) mem[a] = nv;
        if (a == 18) begin
          mem[18] = nv & 32'h3FFFF;
          clr = ~nv[0];
        end
        if (a == 19 && avs_byteenable[0]) begin
          men = avs_writedata[0];
          clr = avs_writedata[1];
        end
      end
      mpend = rise | (mpend & ~clr);
      if (status[1] && !mrun_prev) mcnt = 0;
      if (status[1] && !status[0]) mcnt = mcnt + 1;
      mrun_prev = status[1];
    end
  end

  always @(negedge clk) begin
    if (started === 1'b1) begin
      chk("header", header, {mem[7], mem[6], mem[5], mem[4],
                             mem[3], mem[2], mem[1], mem[0]});
      chk("difficulty", difficulty, {mem[15], mem[14], mem[13], mem[12],
                                     mem[11], mem[10], mem[9], mem[8]});
      chk("start_nonce", 256'(start_nonce), 256'({mem[17], mem[16]}));
      chk("control", 256'(control), 256'(mem[18][17:0]));
      chk("irq_host", 256'(irq_host), 256'(mhost));
      chk("readdatavalid", 256'(avs_readdatavalid), 256'(mrdv));
      chk("waitrequest", 256'(avs_waitrequest), 256'(0));
      if (mrdv) chk("readdata", 256'(avs_readdata), 256'(mrd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    avs_address = a; avs_writedata = d; avs_byteenable = be;
    avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp,
                    input string nm);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    chk({nm, " valid"}, 256'(avs_readdatavalid), 256'(1));
    chk(nm, 256'(avs_readdata), 256'(exp));
  endtask

  initial begin
    rst = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0;
    solution = '0; status = '0; irq = 1'b0;
    repeat (3) tick();
    chk("rst rdv", 256'(avs_readdatavalid), 256'(0));
    chk("rst readdata", 256'(avs_readdata), 256'(0));
    chk("rst irq_host", 256'(irq_host), 256'(0));
    chk("rst control", 256'(control), 256'(0));
    rst = 1'b0;

    for (int i = 0; i <= 21; i++) rd(5'(i), 32'd0, "reset map");
    rd(5'h1F, 32'd0, "unmapped");

    wr(5'h12, 32'd0, 4'hF);
    for (int k = 0; k < 8; k++) wr(5'(k), 32'h11111111 * k, 4'hF);
    chk("header words", header,
        256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000);
    wr(5'h01, 32'hFFFFFFFF, 4'b0001);
    chk("byte lane", 256'(header[63:32]), 256'(32'h111111FF));
    for (int k = 0; k < 8; k++) wr(5'(8 + k), 32'hA0000000 + k, 4'hF);
    chk("difficulty w7", 256'(difficulty[255:224]), 256'(32'hA0000007));
    wr(5'h10, 32'h89ABCDEF, 4'hF);
    wr(5'h11, 32'h01234567, 4'hF);
    chk("nonce", 256'(start_nonce), 256'(64'h0123456789ABCDEF));

    wr(5'h12, 32'd1, 4'hF);
    wr(5'h00, 32'hDEADBEEF, 4'hF);
    wr(5'h10, 32'd0, 4'hF);
    chk("locked header", 256'(header[31:0]), 256'(0));
    chk("locked nonce", 256'(start_nonce), 256'(64'h0123456789ABCDEF));
    wr(5'h12, 32'd0, 4'hF);
    wr(5'h00, 32'hDEADBEEF, 4'hF);
    chk("unlocked header", 256'(header[31:0]), 256'(32'hDEADBEEF));
    wr(5'h12, 32'hFFFFFFFE, 4'hF);
    chk("control 18b", 256'(control), 256'(18'h3FFFE));
    wr(5'h12, 32'd0, 4'hF);

    wr(5'h13, 32'd1, 4'hF);
    irq = 1'b1;
    tick();
    chk("irq_host lag", 256'(irq_host), 256'(0));
    tick();
    chk("irq_host set", 256'(irq_host), 256'(1));
    irq = 1'b0;
    rd(5'h13, 32'h3, "irq reg");
    wr(5'h13, 32'h2, 4'hF);
    tick();
    chk("irq_host w1c", 256'(irq_host), 256'(0));
    rd(5'h13, 32'h0, "irq cleared");

    wr(5'h13, 32'd1, 4'hF);
    irq = 1'b1; tick(); irq = 1'b0; tick();
    irq = 1'b1;
    wr(5'h13, 32'h3, 4'hF);
    irq = 1'b0;
    rd(5'h13, 32'h3, "set wins");
    wr(5'h12, 32'd0, 4'hF);
    rd(5'h13, 32'h1, "ctrl clears");
    chk("irq_host off", 256'(irq_host), 256'(0));

    solution = 64'h0123456789ABCDEF;
    rd(5'h14, 32'h89ABCDEF, "sol lo");
    solution = 64'hFFFFFFFFFFFFFFFF;
    rd(5'h15, 32'h01234567, "sol hi");
    status = 3'b101;
    rd(5'h13, 32'h15, "status ro");
    status = 3'b000;

    avs_address = 5'h02; avs_writedata = 32'd0; avs_byteenable = 4'hF;
    avs_read = 1'b1; avs_write = 1'b1;
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
    chk("rw header", 256'(header[95:64]), 256'(32'h22222222));
    chk("rw read", 256'(avs_readdata), 256'(32'h22222222));

    avs_address = 5'h00; avs_read = 1'b1; rst = 1'b1;
    tick();
    avs_read = 1'b0;
    chk("rst mid-read", 256'(avs_readdatavalid), 256'(0));
    rst = 1'b0;
    tick();
    chk("rst header", header, 256'd0);
    rd(5'h13, 32'h0, "rst irq reg");

`ifdef SHA3_CSR_HASHCNT_EN
    status = 3'b010;
    repeat (100) tick();
    status = 3'b000;
    rd(5'h16, 32'd100, "cnt lo");
    rd(5'h17, 32'd0, "cnt hi");
    status = 3'b010; tick(); status = 3'b000;
    rd(5'h16, 32'd1, "cnt restart");
`else
    rd(5'h16, 32'd0, "no cnt lo");
    rd(5'h17, 32'd0, "no cnt hi");
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
